// File: rtl/branch_redirect_ctrl.sv
// ID-stage branch/jump resolution sequencer: stalls IF/ID until operands are
// forwardable, then holds a redirect request to fetch until it is acknowledged.
module branch_redirect_ctrl #(
  parameter int CNT_WIDTH = 16,
  parameter int MAX_WAIT  = 15
) (
  input  logic                 CLOCK_IN,
  input  logic                 RESET_IN,
  input  logic                 Flush_IN,
  input  logic                 Valid_IN,
  input  logic                 IsBranch_IN,
  input  logic                 IsJump_IN,
  input  logic                 IsJumpReg_IN,
  input  logic                 OperandsReady_IN,
  input  logic                 Taken_IN,
  input  logic [31:0]          Target_IN,
  input  logic                 RedirectAck_IN,
  output logic                 Stall_OUT,
  output logic                 Redirect_OUT,
  output logic [31:0]          RedirectPC_OUT,
  output logic                 Timeout_OUT,
  output logic [CNT_WIDTH-1:0] BranchCount_OUT,
  output logic [CNT_WIDTH-1:0] TakenCount_OUT,
  output logic [CNT_WIDTH-1:0] StallCycles_OUT
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 2);
  localparam logic [WAIT_W-1:0] WAIT_SAT   = WAIT_W'(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_OPS,
    REDIRECT
  } stateT;

  stateT             state;
  stateT             nextState;
  logic              cti;
  logic              needOps;
  logic              resolve;
  logic              enterWait;
  logic [WAIT_W-1:0] waitCnt;
  logic [WAIT_W-1:0] waitNext;

  assign cti     = Valid_IN & (IsBranch_IN | IsJump_IN);
  assign needOps = IsBranch_IN | (IsJump_IN & IsJumpReg_IN);

  always_ff @(posedge CLOCK_IN) begin
    if (RESET_IN) begin
      state           <= IDLE;
      waitCnt         <= '0;
      Redirect_OUT    <= 1'b0;
      RedirectPC_OUT  <= '0;
      Timeout_OUT     <= 1'b0;
      BranchCount_OUT <= '0;
      TakenCount_OUT  <= '0;
      StallCycles_OUT <= '0;
    end else begin
      state        <= nextState;
      waitCnt      <= waitNext;
      Redirect_OUT <= (nextState == REDIRECT);
      if (waitNext > WAIT_LIMIT) Timeout_OUT <= 1'b1;
      if (resolve && Taken_IN) RedirectPC_OUT <= Target_IN;
      if (resolve && (BranchCount_OUT != '1))
        BranchCount_OUT <= BranchCount_OUT + 1'b1;
      if (resolve && Taken_IN && (TakenCount_OUT != '1))
        TakenCount_OUT <= TakenCount_OUT + 1'b1;
      if (Stall_OUT && (StallCycles_OUT != '1))
        StallCycles_OUT <= StallCycles_OUT + 1'b1;
    end
  end

  // CTI inputs are deliberately not decoded in REDIRECT: that slot is the delay slot.
  always_comb begin
    nextState = state;
    resolve   = 1'b0;
    enterWait = 1'b0;
    if (Flush_IN) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (cti) begin
            if (needOps && !OperandsReady_IN) begin
              enterWait = 1'b1;
              nextState = WAIT_OPS;
            end else begin
              resolve   = 1'b1;
              nextState = Taken_IN ? REDIRECT : IDLE;
            end
          end
        end
        WAIT_OPS: begin
          if (OperandsReady_IN) begin
            resolve   = 1'b1;
            nextState = Taken_IN ? REDIRECT : IDLE;
          end
        end
        REDIRECT: begin
          if (RedirectAck_IN) nextState = IDLE;
        end
        default: nextState = IDLE;
      endcase
    end
  end

  // Wait counter tracks stalled cycles of the current CTI and saturates one past the limit.
  always_comb begin
    waitNext = '0;
    if (enterWait) begin
      waitNext = WAIT_W'(1);
    end else if (!Flush_IN && (state == WAIT_OPS) && !OperandsReady_IN) begin
      waitNext = (waitCnt == WAIT_SAT) ? waitCnt : waitCnt + 1'b1;
    end
  end

  always_comb begin
    Stall_OUT = 1'b0;
    if (!RESET_IN && !Flush_IN) begin
      case (state)
        IDLE:     Stall_OUT = cti & needOps & ~OperandsReady_IN;
        WAIT_OPS: Stall_OUT = ~OperandsReady_IN;
        REDIRECT: Stall_OUT = ~RedirectAck_IN;
        default:  Stall_OUT = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed scoreboard bench for branch_redirect_ctrl: expected redirect targets are
// queued by the stimulus and matched by a monitor as redirects appear.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, valid, isBranch, isJump, isJumpReg, opsReady, taken, ack;
  logic [31:0] target;

  logic        stall, redirect, timeout;
  logic [31:0] redirectPc;
  logic [15:0] branchCnt, takenCnt, stallCnt;

  logic        stall4, redirect4, timeout4;
  logic [31:0] redirectPc4;
  logic [3:0]  branchCnt4, takenCnt4, stallCnt4;

  int          totalChecks = 0;
  int          passCount   = 0;
  int          stallSeen   = 0;
  int          redirSeen   = 0;
  logic        prevRedir   = 1'b0;
  logic [31:0] heldPc      = '0;
  logic [31:0] expQ[$];

  branch_redirect_ctrl #(.CNT_WIDTH(16), .MAX_WAIT(15)) dut (
    .CLOCK_IN(clk), .RESET_IN(rst), .Flush_IN(flush), .Valid_IN(valid),
    .IsBranch_IN(isBranch), .IsJump_IN(isJump), .IsJumpReg_IN(isJumpReg),
    .OperandsReady_IN(opsReady), .Taken_IN(taken), .Target_IN(target),
    .RedirectAck_IN(ack), .Stall_OUT(stall), .Redirect_OUT(redirect),
    .RedirectPC_OUT(redirectPc), .Timeout_OUT(timeout),
    .BranchCount_OUT(branchCnt), .TakenCount_OUT(takenCnt), .StallCycles_OUT(stallCnt)
  );

  branch_redirect_ctrl #(.CNT_WIDTH(4), .MAX_WAIT(15)) dut4 (
    .CLOCK_IN(clk), .RESET_IN(rst), .Flush_IN(flush), .Valid_IN(valid),
    .IsBranch_IN(isBranch), .IsJump_IN(isJump), .IsJumpReg_IN(isJumpReg),
    .OperandsReady_IN(opsReady), .Taken_IN(taken), .Target_IN(target),
    .RedirectAck_IN(ack), .Stall_OUT(stall4), .Redirect_OUT(redirect4),
    .RedirectPC_OUT(redirectPc4), .Timeout_OUT(timeout4),
    .BranchCount_OUT(branchCnt4), .TakenCount_OUT(takenCnt4), .StallCycles_OUT(stallCnt4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act === exp) passCount++;
    else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIns();
    flush = 0; valid = 0; isBranch = 0; isJump = 0; isJumpReg = 0;
    opsReady = 0; taken = 0; ack = 0; target = '0;
  endtask

  task automatic doReset();
    clearIns();
    rst = 1;
    step();
    rst = 0;
    stallSeen = 0;
    redirSeen = 0;
  endtask

  task automatic issueBranch(input logic rdy, input logic tk, input logic [31:0] tgt);
    valid = 1; isBranch = 1; isJump = 0; isJumpReg = 0;
    opsReady = rdy; taken = tk; target = tgt;
  endtask

  // Monitor: every new redirect must match the oldest queued target and stay stable while held.
  always @(negedge clk) begin
    if (stall) stallSeen++;
    if (redirect) begin
      redirSeen++;
      if (!prevRedir) begin
        check("redirQueued", expQ.size(), 1);
        if (expQ.size() != 0) check("redirPC", redirectPc, expQ.pop_front());
        heldPc = redirectPc;
      end else begin
        check("pcStable", redirectPc, heldPc);
      end
    end
    prevRedir = redirect;
  end

  initial begin
    clearIns();
    rst = 1;
    step();
    doReset();
    check("rstRedirect", redirect, 0);
    check("rstPC", redirectPc, 0);
    check("rstTimeout", timeout, 0);
    check("rstBranchCnt", branchCnt, 0);
    check("rstStallCnt", stallCnt, 0);

    // BEQ taken, ready, ack in first redirect cycle
    issueBranch(1, 1, 32'h0040_0100);
    expQ.push_back(32'h0040_0100);
    step();
    clearIns();
    ack = 1;
    check("beqRedirectNext", redirect, 1);
    step();
    clearIns();
    step();
    check("beqStallSeen", stallSeen, 0);
    check("beqRedirCycles", redirSeen, 1);
    check("beqBranchCnt", branchCnt, 1);
    check("beqTakenCnt", takenCnt, 1);

    // BNE not taken after 3 operand-wait cycles
    doReset();
    for (int i = 0; i < 3; i++) begin
      issueBranch(0, 0, 32'h0040_0200);
      step();
    end
    issueBranch(1, 0, 32'h0040_0200);
    step();
    clearIns();
    step();
    check("bneStallSeen", stallSeen, 3);
    check("bneStallCnt", stallCnt, 3);
    check("bneRedirCycles", redirSeen, 0);
    check("bneTakenCnt", takenCnt, 0);
    check("bneBranchCnt", branchCnt, 1);

    // Direct J never waits, even with operands not ready
    doReset();
    valid = 1; isJump = 1; isJumpReg = 0; opsReady = 0; taken = 1; target = 32'h0040_0300;
    expQ.push_back(32'h0040_0300);
    step();
    clearIns();
    ack = 1;
    check("jRedirectNext", redirect, 1);
    step();
    clearIns();
    step();
    check("jStallSeen", stallSeen, 0);
    check("jBranchCnt", branchCnt, 1);

    // Taken branch, ack delayed 4 cycles; an illegal CTI in the delay slot is ignored
    doReset();
    issueBranch(1, 1, 32'h0040_0400);
    expQ.push_back(32'h0040_0400);
    step();
    issueBranch(1, 1, 32'h0BAD_0000);
    for (int i = 0; i < 4; i++) step();
    ack = 1;
    step();
    clearIns();
    step();
    check("ackDlyRedirCycles", redirSeen, 5);
    check("ackDlyStallSeen", stallSeen, 4);
    check("ackDlyStallCnt", stallCnt, 4);
    check("ackDlyBranchCnt", branchCnt, 1);

    // Operand wait of MAX_WAIT+2 cycles, then flush
    doReset();
    for (int i = 0; i < 17; i++) begin
      issueBranch(0, 1, 32'h0040_0500);
      if (i == 15) check("toBelowLimit", timeout, 0);
      if (i == 16) check("toAtLimit", timeout, 1);
      step();
    end
    flush = 1;
    #1;
    check("flushStall", stall, 0);
    step();
    clearIns();
    #1;
    check("flushIdle", stall, 0);
    check("flushNoRedir", redirect, 0);
    step();
    step();
    check("toSticky", timeout, 1);
    check("toStallSeen", stallSeen, 17);
    check("toBranchCnt", branchCnt, 0);
    check("toRedirCycles", redirSeen, 0);

    // 20 taken branches: 4-bit counters saturate, 16-bit keep counting
    doReset();
    for (int i = 0; i < 20; i++) begin
      issueBranch(1, 1, 32'h0041_0000 + 32'(i * 4));
      expQ.push_back(32'h0041_0000 + 32'(i * 4));
      step();
      clearIns();
      ack = 1;
      step();
      clearIns();
    end
    step();
    check("satBranchCnt4", branchCnt4, 15);
    check("satTakenCnt4", takenCnt4, 15);
    check("satBranchCnt16", branchCnt, 20);
    check("satTakenCnt16", takenCnt, 20);
    check("satRedirCycles", redirSeen, 20);

    // Flush together with ack: flush wins, nothing counted twice
    doReset();
    issueBranch(1, 1, 32'h0040_0800);
    expQ.push_back(32'h0040_0800);
    step();
    clearIns();
    flush = 1; ack = 1;
    step();
    clearIns();
    check("flushAckRedirect", redirect, 0);
    step();
    check("flushAckBranchCnt", branchCnt, 1);
    check("flushAckTakenCnt", takenCnt, 1);
    check("flushAckStallSeen", stallSeen, 0);

    // Reset while redirect is pending and unacknowledged
    doReset();
    issueBranch(1, 1, 32'h0040_0900);
    expQ.push_back(32'h0040_0900);
    step();
    clearIns();
    step();
    rst = 1;
    #1;
    check("rstCycleStall", stall, 0);
    step();
    check("midRstRedirect", redirect, 0);
    check("midRstPC", redirectPc, 0);
    check("midRstBranchCnt", branchCnt, 0);
    check("midRstTakenCnt", takenCnt, 0);
    check("midRstStallCnt", stallCnt, 0);
    rst = 0;
    step();
    check("queueEmpty", expQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, totalChecks);
    $finish;
  end

endmodule
